// File: rtl/counters_pkg.sv
// ============================================================================
// Module   : counters_pkg
// Brief    : Shared state encodings and types for the counters library.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counters_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    // 2'd3 is unused; the timer falls back to IDLE if it is ever seen.
    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_RUN     = ST_RUN,
        S_EXPIRED = ST_EXPIRED
    } timer_state_t;

endpackage

`default_nettype wire

// File: rtl/nbit_down_timer_if.sv
// ============================================================================
// Module   : nbit_down_timer_if
// Brief    : Control and status bundle for the N-bit down timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nbit_down_timer_if #(
    parameter int N = 32
);
    logic [N-1:0] pl;
    logic         load;
    logic         en;
    logic         periodic;
    logic [N-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    modport master (
        output pl, load, en, periodic,
        input  count, tc, busy, done
    );

    modport slave (
        input  pl, load, en, periodic,
        output count, tc, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/nbit_down_timer.sv
// ============================================================================
// Module   : nbit_down_timer
// Brief    : Programmable N-bit down timer, one-shot or auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nbit_down_timer
    import counters_pkg::*;
#(
    parameter int           N    = 32,
    parameter logic [N-1:0] DEC  = 1,
    parameter logic [N-1:0] SEED = '0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    nbit_down_timer_if.slave   bus
);

    generate
        if (DEC == '0) begin : g_bad_dec
            $error("nbit_down_timer: DEC must be non-zero");
        end
    endgenerate

    timer_state_t state;
    logic [N-1:0] count_q;
    logic [N-1:0] reload_q;
    logic         tc_q;
    logic         terminal;

    // Saturating terminal detect: the final step never wraps below zero.
    assign terminal = (count_q <= DEC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count_q  <= '0;
            reload_q <= SEED;
            tc_q     <= 1'b0;
        end else if (bus.load) begin
            count_q  <= bus.pl;
            reload_q <= bus.pl;
            if (bus.pl != '0) begin
                state <= S_RUN;
                tc_q  <= 1'b0;
            end else begin
                state <= S_EXPIRED;
                tc_q  <= 1'b1;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (!bus.en) begin
                        tc_q <= 1'b0;
                    end else if (!terminal) begin
                        count_q <= count_q - DEC;
                        tc_q    <= 1'b0;
                    end else begin
                        tc_q <= 1'b1;
                        if (bus.periodic) begin
                            count_q <= reload_q;
                        end else begin
                            count_q <= '0;
                            state   <= S_EXPIRED;
                        end
                    end
                end
                S_IDLE, S_EXPIRED: begin
                    tc_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    tc_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state == S_RUN);
    assign bus.done  = (state == S_EXPIRED);

endmodule

`default_nettype wire

// File: tb/tb_nbit_down_timer.sv
// ============================================================================
// Module   : tb_nbit_down_timer
// Brief    : Directed self-checking bench for nbit_down_timer (DEC=1 and DEC=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nbit_down_timer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    nbit_down_timer_if #(.N(8)) if1 ();
    nbit_down_timer_if #(.N(8)) if3 ();

    nbit_down_timer #(.N(8), .DEC(8'd1), .SEED(8'h10)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    nbit_down_timer #(.N(8), .DEC(8'd3), .SEED(8'h10)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks count/tc/busy/done of one timer in a single call.
    task automatic chk1(input string tag, input logic [7:0] c, input logic t,
                        input logic b, input logic d);
        chk({tag, ".count"}, {24'd0, if1.count}, {24'd0, c});
        chk({tag, ".tc"},    {31'd0, if1.tc},    {31'd0, t});
        chk({tag, ".busy"},  {31'd0, if1.busy},  {31'd0, b});
        chk({tag, ".done"},  {31'd0, if1.done},  {31'd0, d});
    endtask

    task automatic chk3(input string tag, input logic [7:0] c, input logic t,
                        input logic b, input logic d);
        chk({tag, ".count"}, {24'd0, if3.count}, {24'd0, c});
        chk({tag, ".tc"},    {31'd0, if3.tc},    {31'd0, t});
        chk({tag, ".busy"},  {31'd0, if3.busy},  {31'd0, b});
        chk({tag, ".done"},  {31'd0, if3.done},  {31'd0, d});
    endtask

    initial begin
        logic [7:0] exp_seq [6];
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        if1.pl = '0; if1.load = 1'b0; if1.en = 1'b0; if1.periodic = 1'b0;
        if3.pl = '0; if3.load = 1'b0; if3.en = 1'b0; if3.periodic = 1'b0;

        // Reset for two cycles.
        tick();
        tick();
        chk1("rst_d1", 8'd0, 1'b0, 1'b0, 1'b0);
        chk3("rst_d3", 8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Zero load expires immediately even in periodic mode.
        if1.periodic = 1'b1; if1.pl = 8'd0; if1.load = 1'b1;
        tick();
        chk1("zero_load", 8'd0, 1'b1, 1'b0, 1'b1);
        if1.load = 1'b0; if1.en = 1'b1;
        tick();
        chk1("zero_load_after", 8'd0, 1'b0, 1'b0, 1'b1);

        // One-shot countdown 5..0.
        if1.periodic = 1'b0; if1.pl = 8'd5; if1.load = 1'b1; if1.en = 1'b1;
        tick();
        chk1("os_load", 8'd5, 1'b0, 1'b1, 1'b0);
        if1.load = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            tick();
            chk1("os_run", 8'(i), 1'b0, 1'b1, 1'b0);
        end
        tick();
        chk1("os_term", 8'd0, 1'b1, 1'b0, 1'b1);
        tick();
        chk1("os_exp1", 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk1("os_exp2", 8'd0, 1'b0, 1'b0, 1'b1);

        // Periodic with saturating final step: 7,4,1,7,4,1,7.
        if3.periodic = 1'b1; if3.pl = 8'd7; if3.load = 1'b1; if3.en = 1'b1;
        tick();
        chk3("per_load", 8'd7, 1'b0, 1'b1, 1'b0);
        if3.load = 1'b0;
        exp_seq = '{8'd4, 8'd1, 8'd7, 8'd4, 8'd1, 8'd7};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk3("per_run", exp_seq[i], (i == 2 || i == 5), 1'b1, 1'b0);
        end

        // Reload value not above DEC: tc every enabled cycle.
        if3.pl = 8'd2; if3.load = 1'b1;
        tick();
        chk3("per_small_load", 8'd2, 1'b0, 1'b1, 1'b0);
        if3.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3("per_small", 8'd2, 1'b1, 1'b1, 1'b0);
        end
        if3.en = 1'b0;

        // Enable gating: 4,3,3,3,2.
        if1.pl = 8'd4; if1.load = 1'b1; if1.en = 1'b0;
        tick();
        chk1("gate_load", 8'd4, 1'b0, 1'b1, 1'b0);
        if1.load = 1'b0; if1.en = 1'b1;
        tick();
        chk1("gate_en1", 8'd3, 1'b0, 1'b1, 1'b0);
        if1.en = 1'b0;
        tick();
        chk1("gate_hold1", 8'd3, 1'b0, 1'b1, 1'b0);
        tick();
        chk1("gate_hold2", 8'd3, 1'b0, 1'b1, 1'b0);
        if1.en = 1'b1;
        tick();
        chk1("gate_en2", 8'd2, 1'b0, 1'b1, 1'b0);

        // Load beats a would-be terminal.
        tick();
        chk1("sim_at1", 8'd1, 1'b0, 1'b1, 1'b0);
        if1.pl = 8'd9; if1.load = 1'b1;
        tick();
        chk1("sim_load_wins", 8'd9, 1'b0, 1'b1, 1'b0);

        // Reset beats load at count=1.
        if1.pl = 8'd1;
        tick();
        chk1("sim_pre_rst", 8'd1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1; if1.pl = 8'd5;
        tick();
        chk1("sim_rst_wins", 8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; if1.load = 1'b0;

        // Reset in the middle of a long run.
        if1.pl = 8'd200; if1.load = 1'b1; if1.en = 1'b1;
        tick();
        if1.load = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk1("mid_run", 8'd150, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk1("mid_rst", 8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        chk1("idle_en", 8'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nbit_down_timer.md
Name: nbit_down_timer

Overview:
- N-bit programmable down-counting timer; the count-down counterpart to the team's N-bit up-counter.
- Loaded with a start value, it decrements by a fixed step on each enabled cycle and flags terminal count (TC) when the count reaches zero.
- Supports one-shot and periodic (auto-reload) modes.
- Used as a timeout, tick generator and interval timer alongside the up-counters in the counters library.

Parameters:
- N, 32, counter width in bits.
- DEC, 1, decrement per enabled cycle; legal range 1 <= DEC < 2^N. Elaboration-time check fails on DEC=0.
- SEED, 0, reset value of the internal reload register.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- pl  input  N  parallel load value.
- load  input  1  load strobe: captures pl into count and the reload register.
- en  input  1  count enable; decrement only when high.
- periodic  input  1  1 = auto-reload on TC, 0 = one-shot. Sampled on the TC cycle.
- count  output  N  current count, registered.
- tc  output  1  terminal-count pulse, registered, 1 cycle wide.
- busy  output  1  high while in RUN.
- done  output  1  high while in EXPIRED.

Behaviour:
- Priority on every edge: rst > load > en.
- Reset (rst=1 at posedge):
  - count=0, reload_q=SEED, state=IDLE.
  - tc=0, busy=0, done=0.
  - Reset mid-RUN aborts with no tc.
- States:
  - IDLE: count holds; en ignored.
  - RUN: counting.
  - EXPIRED: count held at 0; en ignored.
  - EXPIRED and IDLE are left only by load or rst.
- Load (load=1, rst=0), from any state:
  - count<=pl, reload_q<=pl, tc<=0.
  - If pl!=0, state<=RUN.
  - If pl==0, state<=EXPIRED with tc<=1 on the same edge. A zero load counts as immediate expiry regardless of periodic.
  - A load in the same cycle as a would-be TC wins: no tc pulse, count=pl.
- RUN with en=0: count holds; tc<=0.
- RUN with en=1 and count > DEC: count<=count-DEC; tc<=0.
- RUN with en=1 and count <= DEC (terminal). Saturating: no wrap below 0. tc<=1, then:
  - periodic=1: count<=reload_q, stay RUN.
  - periodic=0: count<=0, state<=EXPIRED.
- Periodic with reload_q <= DEC gives tc=1 on every enabled cycle.
- Latency:
  - count reflects a load one cycle after the load edge.
  - tc is high in the cycle immediately after the terminal edge. In one-shot mode this is the same cycle done first goes high.
- busy and done are decoded from the state register; both are registered-equivalent.
- tc never asserts in IDLE. In EXPIRED it asserts only as the terminal pulse on the entry edge.
- Changing periodic mid-RUN takes effect at the next terminal event only.

Decomposition:
- Shared package/header counters_pkg:
  - State encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_EXPIRED=2'd2.
  - 2'd3 is illegal and recovers to IDLE.
- No sub-module needed. Single module:
  - State register.
  - Count/reload datapath with a comparator (count <= DEC).
  - Registered tc.

Test Plan:
- Reset: N=8, SEED=8'h10; assert rst 2 cycles -> count=0, tc=0, busy=0, done=0. Then periodic=1, load pl=0 -> tc=1 the next cycle, done=1.
- One-shot: N=8, DEC=1; load pl=5, en=1, periodic=0 -> count 5,4,3,2,1,0 on successive cycles. tc=1 exactly once, when count first shows 0; done=1 from then on; further en leaves count=0 with no tc.
- Periodic with saturation: DEC=3, load pl=7, periodic=1, en=1 -> count 7,4,1,7,4,1… with tc=1 in each cycle count shows 7 after a 1. Also check pl=2, DEC=3 -> tc every cycle, count stays 2.
- Enable gating: load pl=4, toggle en 1,0,0,1 -> count 4,3,3,3,2, with no tc during the hold cycles.
- Simultaneous events:
  - At count=1 with en=1, assert load pl=9 -> count=9 and no tc.
  - At count=1, assert rst and load together -> count=0, state IDLE, no tc.
- Reset mid-run: load pl=200, run 50 cycles, rst=1 -> count=0, busy=0 next cycle, no tc. Then en=1 without load -> count stays 0.
